// File: rtl/mem_ctrl_if.sv
// Request/response and byte-bus bundle of mem_ctrl.
// io_buffer_full exists only when MEM_CTRL_IO_STALL_EN is defined.
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              inst_read_flag;
    logic [ADDR_W-1:0] inst_read_addr;
    logic              inst_flag;
    logic [DATA_W-1:0] inst;
    logic              data_req;
    logic              data_we;
    logic [1:0]        data_len;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_done;
    logic [DATA_W-1:0] data_rdata;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
`ifdef MEM_CTRL_IO_STALL_EN
    logic              io_buffer_full;
`endif

    // Controller view
    modport slave (
`ifdef MEM_CTRL_IO_STALL_EN
        input  io_buffer_full,
`endif
        input  inst_read_flag, inst_read_addr, data_req, data_we, data_len,
               data_addr, data_wdata, mem_din,
        output inst_flag, inst, data_done, data_rdata, mem_dout, mem_a, mem_wr
    );

    // Requester / RAM view
    modport master (
`ifdef MEM_CTRL_IO_STALL_EN
        output io_buffer_full,
`endif
        output inst_read_flag, inst_read_addr, data_req, data_we, data_len,
               data_addr, data_wdata, mem_din,
        input  inst_flag, inst, data_done, data_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates fetch/data requests onto a byte-wide RAM bus, little-endian.
// Optional IO write stall when MEM_CTRL_IO_STALL_EN is defined.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    mem_ctrl_if.slave bus
);
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {IDLE, IREAD, DREAD, DWRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, nbytes_q, nbytes_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, word_q, word_d;
    logic [DATA_W-1:0] inst_q, inst_d, rdata_q, rdata_d;
    logic [BYTE_W-1:0] dout_q, dout_d;
    logic              wr_q, wr_d, iflag_q, iflag_d, done_q, done_d;
    logic              stall_c;
    logic [CNT_W-1:0]  cnt_inc_c, dlen_bytes_c;
    logic [1:0]        rd_idx_c, wr_idx_c;

    assign cnt_inc_c    = cnt_q + CNT_W'(1);
    assign rd_idx_c     = 2'(cnt_q - CNT_W'(1));
    assign wr_idx_c     = 2'(cnt_inc_c);
    assign dlen_bytes_c = (bus.data_len == 2'd0) ? CNT_W'(1) :
                          (bus.data_len == 2'd1) ? CNT_W'(2) : CNT_W'(4);

`ifdef MEM_CTRL_IO_STALL_EN
    logic io_space_q;

    // Remember whether the latched data address lies in IO space
    always_ff @(posedge clk) begin
        if (rst) begin
            io_space_q <= 1'b0;
        end else if (rdy && state_q == IDLE && bus.data_req) begin
            io_space_q <= (bus.data_addr[17:16] == 2'b11);
        end
    end

    assign stall_c = (state_q == DWRITE) && io_space_q && bus.io_buffer_full;
`else
    assign stall_c = 1'b0;
`endif

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        nbytes_d = nbytes_q;
        mem_a_d  = mem_a_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        inst_d   = inst_q;
        rdata_d  = rdata_q;
        dout_d   = dout_q;
        wr_d     = wr_q;
        iflag_d  = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.data_req) begin
                    mem_a_d  = bus.data_addr;
                    wdata_d  = bus.data_wdata;
                    nbytes_d = dlen_bytes_c;
                    cnt_d    = '0;
                    word_d   = '0;
                    if (bus.data_we) begin
                        state_d = DWRITE;
                        wr_d    = 1'b1;
                        dout_d  = bus.data_wdata[BYTE_W-1:0];
                    end else begin
                        state_d = DREAD;
                    end
                end else if (bus.inst_read_flag) begin
                    mem_a_d  = bus.inst_read_addr;
                    nbytes_d = CNT_W'(4);
                    cnt_d    = '0;
                    word_d   = '0;
                    state_d  = IREAD;
                end
            end
            IREAD, DREAD: begin
                if (state_q == IREAD && !bus.inst_read_flag) begin
                    state_d = IDLE;
                end else begin
                    // Byte for address index cnt-1 arrives one cycle after its address
                    if (cnt_q != '0) word_d[{rd_idx_c, 3'b000} +: BYTE_W] = bus.mem_din;
                    if (cnt_q == nbytes_q) begin
                        state_d = DONE;
                        if (state_q == IREAD) begin
                            iflag_d = 1'b1;
                            inst_d  = word_d;
                        end else begin
                            done_d  = 1'b1;
                            rdata_d = word_d;
                        end
                    end else begin
                        cnt_d = cnt_inc_c;
                        if (cnt_inc_c < nbytes_q) mem_a_d = mem_a_q + ADDR_W'(1);
                    end
                end
            end
            DWRITE: begin
                if (!stall_c) begin
                    if (cnt_inc_c == nbytes_q) begin
                        state_d = DONE;
                        wr_d    = 1'b0;
                        done_d  = 1'b1;
                        rdata_d = '0;
                    end else begin
                        cnt_d   = cnt_inc_c;
                        mem_a_d = mem_a_q + ADDR_W'(1);
                        dout_d  = wdata_q[{wr_idx_c, 3'b000} +: BYTE_W];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; rdy=0 freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            nbytes_q <= '0;
            mem_a_q  <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
            inst_q   <= '0;
            rdata_q  <= '0;
            dout_q   <= '0;
            wr_q     <= 1'b0;
            iflag_q  <= 1'b0;
            done_q   <= 1'b0;
        end else if (rdy) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nbytes_q <= nbytes_d;
            mem_a_q  <= mem_a_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            inst_q   <= inst_d;
            rdata_q  <= rdata_d;
            dout_q   <= dout_d;
            wr_q     <= wr_d;
            iflag_q  <= iflag_d;
            done_q   <= done_d;
        end
    end

    assign bus.inst_flag  = iflag_q;
    assign bus.inst       = inst_q;
    assign bus.data_done  = done_q;
    assign bus.data_rdata = rdata_q;
    assign bus.mem_a      = mem_a_q;
    assign bus.mem_dout   = dout_q;
    assign bus.mem_wr     = wr_q & rdy & ~stall_c;
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM emulation plus a word-level reference memory.
// Define MEM_CTRL_IO_STALL_EN to also exercise the IO write stall.
`timescale 1ns/1ps
module tb_mem_ctrl;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   n_checks = 0;
    int   n_pass   = 0;

    mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0] ram       [logic [31:0]];
    logic [7:0] model_mem [logic [31:0]];
    string out_names [7] = '{"inst_flag", "inst", "data_done", "data_rdata", "mem_a", "mem_dout", "mem_wr"};

    function automatic logic [7:0] fill_byte(input logic [31:0] a);
        return 8'(a * 32'd37 + (a >> 8) + 32'd5);
    endfunction
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : fill_byte(a);
    endfunction
    function automatic logic [7:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : fill_byte(a);
    endfunction
    function automatic int len_bytes(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction
    function automatic logic [31:0] model_word(input logic [31:0] a, input int n);
        logic [31:0] w = 32'd0;
        for (int k = 0; k < n; k++) w = w | (32'(model_rd(a + 32'(k))) << (8 * k));
        return w;
    endfunction
    task automatic model_write(input logic [31:0] a, input int n, input logic [31:0] wd);
        for (int k = 0; k < n; k++) model_mem[a + 32'(k)] = wd[8*k +: 8];
    endtask
    task automatic preload(input logic [31:0] a, input logic [7:0] v);
        ram[a] = v;
        model_mem[a] = v;
    endtask

    // Byte RAM with one-cycle read latency
    always @(posedge clk) begin
        bus.mem_din <= ram_rd(bus.mem_a);
        if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    end

    logic [31:0] obs_a [$];
    logic        obs_wr [$];
    logic [7:0]  obs_dout [$];
    int          obs_cyc;
    logic        obs_i, obs_d;
    logic [31:0] obs_val;

    task automatic req_fetch(input logic [31:0] a);
        bus.inst_read_flag = 1'b1;
        bus.inst_read_addr = a;
    endtask
    task automatic req_data(input logic we, input logic [1:0] len, input logic [31:0] a, input logic [31:0] wd);
        bus.data_req   = 1'b1;
        bus.data_we    = we;
        bus.data_len   = len;
        bus.data_addr  = a;
        bus.data_wdata = wd;
    endtask

    // Records the bus each cycle until a completion pulse or the budget runs out
    task automatic observe(input int budget);
        obs_a.delete(); obs_wr.delete(); obs_dout.delete();
        obs_cyc = -1; obs_i = 1'b0; obs_d = 1'b0; obs_val = 32'd0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            obs_a.push_back(bus.mem_a);
            obs_wr.push_back(bus.mem_wr);
            obs_dout.push_back(bus.mem_dout);
            if (bus.inst_flag || bus.data_done) begin
                obs_cyc = c;
                obs_i   = bus.inst_flag;
                obs_d   = bus.data_done;
                obs_val = bus.inst_flag ? bus.inst : bus.data_rdata;
                bus.inst_read_flag = 1'b0;
                bus.data_req       = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] got [7];
        rst = 1'b1;
        rdy = 1'b1;
        repeat (2) @(negedge clk);
        got[0] = 32'(bus.inst_flag); got[1] = bus.inst; got[2] = 32'(bus.data_done);
        got[3] = bus.data_rdata; got[4] = bus.mem_a; got[5] = 32'(bus.mem_dout); got[6] = 32'(bus.mem_wr);
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (got[i] !== 32'd0) $display("FAIL reset_%s: got 0x%0h, want 0", out_names[i], got[i]);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        logic ok;
        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h00); preload(32'h103, 8'h00);
        req_fetch(32'h100);
        observe(12);
        n_checks++;
        if (obs_cyc !== 5 || obs_i !== 1'b1) $display("FAIL fetch_latency: got cycle %0d flag %0b, want cycle 5 flag 1", obs_cyc, obs_i);
        else n_pass++;
        n_checks++;
        if (obs_val !== 32'h0000_0513) $display("FAIL fetch_inst: got 0x%08h, want 0x00000513", obs_val);
        else n_pass++;
        ok = (obs_a.size() >= 4);
        for (int k = 0; k < 4 && ok; k++) ok = (obs_a[k] === 32'h100 + 32'(k)) && (obs_wr[k] === 1'b0);
        n_checks++;
        if (!ok) $display("FAIL fetch_addr_seq: first addr 0x%0h, want 0x100..0x103 with mem_wr=0", obs_a[0]);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.inst_flag !== 1'b0) $display("FAIL fetch_pulse: inst_flag got %0b one cycle later, want 0", bus.inst_flag);
        else n_pass++;
    endtask

    task automatic test_store();
        logic [7:0] eb [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        logic ok;
        model_write(32'h20, 4, 32'hDEAD_BEEF);
        req_data(1'b1, 2'd3, 32'h20, 32'hDEAD_BEEF);
        observe(10);
        n_checks++;
        if (obs_cyc !== 4 || obs_d !== 1'b1 || obs_val !== 32'd0)
            $display("FAIL store_done: got cycle %0d done %0b rdata 0x%0h, want cycle 4 done 1 rdata 0", obs_cyc, obs_d, obs_val);
        else n_pass++;
        ok = (obs_a.size() >= 4);
        for (int k = 0; k < 4 && ok; k++)
            ok = (obs_wr[k] === 1'b1) && (obs_a[k] === 32'h20 + 32'(k)) && (obs_dout[k] === eb[k]);
        n_checks++;
        if (!ok) $display("FAIL store_bus_seq: first addr 0x%0h byte 0x%0h, want EF,BE,AD,DE at 0x20..0x23", obs_a[0], obs_dout[0]);
        else n_pass++;
        n_checks++;
        if (model_word(32'h20, 4) !== {ram_rd(32'h23), ram_rd(32'h22), ram_rd(32'h21), ram_rd(32'h20)})
            $display("FAIL store_ram: got 0x%02h%02h%02h%02h, want 0xdeadbeef", ram_rd(32'h23), ram_rd(32'h22), ram_rd(32'h21), ram_rd(32'h20));
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_priority();
        int dcyc = -1;
        int icyc = -1;
        logic [31:0] dval = 32'd0;
        logic [31:0] ival = 32'd0;
        logic [31:0] a_at [$];
        preload(32'h40, 8'h80);
        req_fetch(32'h0);
        req_data(1'b0, 2'd0, 32'h40, 32'd0);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            a_at.push_back(bus.mem_a);
            if (bus.data_done) begin
                if (dcyc < 0) dcyc = c;
                dval = bus.data_rdata;
                bus.data_req = 1'b0;
            end
            if (bus.inst_flag) begin
                if (icyc < 0) icyc = c;
                ival = bus.inst;
                bus.inst_read_flag = 1'b0;
            end
        end
        n_checks++;
        if (dcyc !== 2 || dval !== 32'h0000_0080 || a_at[0] !== 32'h40)
            $display("FAIL prio_data: got cycle %0d rdata 0x%0h addr0 0x%0h, want cycle 2 rdata 0x80 addr0 0x40", dcyc, dval, a_at[0]);
        else n_pass++;
        n_checks++;
        if (icyc !== 9 || a_at[4] !== 32'h0)
            $display("FAIL prio_fetch_timing: got flag cycle %0d addr@4 0x%0h, want cycle 9 addr 0", icyc, a_at[4]);
        else n_pass++;
        n_checks++;
        if (ival !== model_word(32'h0, 4)) $display("FAIL prio_fetch_inst: got 0x%08h, want 0x%08h", ival, model_word(32'h0, 4));
        else n_pass++;
    endtask

    task automatic test_abort();
        logic seen = 1'b0;
        req_fetch(32'h8);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen = seen | bus.inst_flag;
            if (c == 2) bus.inst_read_flag = 1'b0;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL abort_no_flag: inst_flag got 1 after flush, want 0");
        else n_pass++;
        req_fetch(32'h40);
        observe(12);
        n_checks++;
        if (obs_cyc !== 5 || obs_a[0] !== 32'h40)
            $display("FAIL abort_refetch_timing: got cycle %0d addr0 0x%0h, want cycle 5 addr0 0x40", obs_cyc, obs_a[0]);
        else n_pass++;
        n_checks++;
        if (obs_val !== model_word(32'h40, 4)) $display("FAIL abort_refetch_inst: got 0x%08h, want 0x%08h", obs_val, model_word(32'h40, 4));
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_freeze_reset();
        logic [31:0] a  = 32'h1000 + 32'($urandom_range(0, 32'hFFF));
        logic [31:0] wd = $urandom;
        logic [31:0] b  = 32'h2000 + 32'($urandom_range(0, 32'hFFF));
        logic [31:0] got [7];
        logic ok = 1'b1;
        model_write(a, 4, wd);
        req_data(1'b1, 2'd3, a, wd);
        @(negedge clk);
        @(negedge clk);
        rdy = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            ok = ok && (bus.mem_wr === 1'b0) && (bus.mem_a === a + 32'd1) && (bus.data_done === 1'b0);
        end
        n_checks++;
        if (!ok) $display("FAIL freeze_hold: mem_wr %0b mem_a 0x%0h, want 0 and 0x%0h", bus.mem_wr, bus.mem_a, a + 32'd1);
        else n_pass++;
        rdy = 1'b1;
        observe(8);
        n_checks++;
        if (obs_cyc !== 2 || obs_a[0] !== a + 32'd2 || obs_wr[0] !== 1'b1)
            $display("FAIL freeze_resume: got done cycle %0d addr0 0x%0h, want 2 and 0x%0h", obs_cyc, obs_a[0], a + 32'd2);
        else n_pass++;
        n_checks++;
        if (model_word(a, 4) !== {ram_rd(a + 32'd3), ram_rd(a + 32'd2), ram_rd(a + 32'd1), ram_rd(a)})
            $display("FAIL freeze_ram: got 0x%02h%02h%02h%02h, want 0x%08h", ram_rd(a + 32'd3), ram_rd(a + 32'd2), ram_rd(a + 32'd1), ram_rd(a), wd);
        else n_pass++;
        @(negedge clk);
        req_data(1'b0, 2'd3, b, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        got[0] = 32'(bus.inst_flag); got[1] = bus.inst; got[2] = 32'(bus.data_done);
        got[3] = bus.data_rdata; got[4] = bus.mem_a; got[5] = 32'(bus.mem_dout); got[6] = 32'(bus.mem_wr);
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (got[i] !== 32'd0) $display("FAIL midreset_%s: got 0x%0h, want 0", out_names[i], got[i]);
            else n_pass++;
        end
        bus.data_req = 1'b0;
        rst = 1'b0;
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            ok = ok && (bus.data_done === 1'b0) && (bus.inst_flag === 1'b0);
        end
        n_checks++;
        if (!ok) $display("FAIL midreset_no_done: completion pulse after aborted read, want none");
        else n_pass++;
        req_fetch(b);
        observe(12);
        n_checks++;
        if (obs_cyc !== 5 || obs_val !== model_word(b, 4))
            $display("FAIL midreset_refetch: got cycle %0d inst 0x%08h, want 5 and 0x%08h", obs_cyc, obs_val, model_word(b, 4));
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random();
        int kind, n, exp_cyc;
        logic [1:0]  len;
        logic [31:0] a, wd, exp_val;
        logic ok;
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 2);
            len  = 2'($urandom_range(0, 3));
            a    = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 255));
            wd   = $urandom;
            if (t == 0) begin kind = 2; len = 2'd3; a = 32'hFFFF_FFFE; end
            if (t == 1) begin kind = 1; len = 2'd3; a = 32'hFFFF_FFFE; end
            if (t == 2) begin kind = 1; len = 2'd2; end
            n       = (kind == 0) ? 4 : len_bytes(len);
            exp_cyc = (kind == 2) ? n : n + 1;
            exp_val = (kind == 2) ? 32'd0 : model_word(a, n);
            if (kind == 2) model_write(a, n, wd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (kind == 0) req_fetch(a);
            else req_data(kind == 2, len, a, wd);
            observe(n + 6);
            n_checks++;
            if (obs_cyc !== exp_cyc) $display("FAIL rnd%0d_latency: got cycle %0d, want %0d (kind %0d)", t, obs_cyc, exp_cyc, kind);
            else n_pass++;
            n_checks++;
            if ((kind == 0) ? !(obs_i && !obs_d) : !(obs_d && !obs_i))
                $display("FAIL rnd%0d_flag: got inst_flag %0b data_done %0b, kind %0d", t, obs_i, obs_d, kind);
            else n_pass++;
            n_checks++;
            if (obs_val !== exp_val) $display("FAIL rnd%0d_value: got 0x%08h, want 0x%08h", t, obs_val, exp_val);
            else n_pass++;
            ok = (obs_a.size() >= n);
            for (int k = 0; k < n && ok; k++)
                ok = (obs_a[k] === a + 32'(k)) && (obs_wr[k] === (kind == 2)) && (kind != 2 || obs_dout[k] === wd[8*k +: 8]);
            for (int k = n; k < obs_wr.size() && ok; k++) ok = (obs_wr[k] === 1'b0);
            n_checks++;
            if (!ok) $display("FAIL rnd%0d_bus_seq: addr0 0x%0h wr0 %0b, want 0x%0h wr %0b", t, obs_a[0], obs_wr[0], a, kind == 2);
            else n_pass++;
            if (kind == 2) begin
                ok = 1'b1;
                for (int k = 0; k < n; k++) ok = ok && (ram_rd(a + 32'(k)) === model_rd(a + 32'(k)));
                n_checks++;
                if (!ok) $display("FAIL rnd%0d_ram: RAM byte at 0x%0h is 0x%0h, want 0x%0h", t, a, ram_rd(a), model_rd(a));
                else n_pass++;
            end
            @(negedge clk);
            n_checks++;
            if (bus.inst_flag !== 1'b0 || bus.data_done !== 1'b0)
                $display("FAIL rnd%0d_pulse: flags %0b/%0b one cycle after completion, want 0/0", t, bus.inst_flag, bus.data_done);
            else n_pass++;
        end
    endtask

`ifdef MEM_CTRL_IO_STALL_EN
    task automatic test_io_stall();
        logic [7:0] v = 8'($urandom);
        logic ok = 1'b1;
        model_write(32'h3_0000, 1, 32'(v));
        bus.io_buffer_full = 1'b1;
        req_data(1'b1, 2'd0, 32'h3_0000, 32'(v));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ok = ok && (bus.mem_wr === 1'b0) && (bus.data_done === 1'b0);
        end
        n_checks++;
        if (!ok) $display("FAIL io_stall_hold: mem_wr %0b during full buffer, want 0", bus.mem_wr);
        else n_pass++;
        @(posedge clk);
        #1 bus.io_buffer_full = 1'b0;
        observe(6);
        n_checks++;
        if (obs_cyc !== 1 || obs_wr[0] !== 1'b1 || obs_a[0] !== 32'h3_0000)
            $display("FAIL io_stall_resume: got done cycle %0d wr0 %0b addr0 0x%0h, want 1, 1, 0x30000", obs_cyc, obs_wr[0], obs_a[0]);
        else n_pass++;
        n_checks++;
        if (ram_rd(32'h3_0000) !== model_rd(32'h3_0000)) $display("FAIL io_stall_ram: got 0x%0h, want 0x%0h", ram_rd(32'h3_0000), v);
        else n_pass++;
        @(negedge clk);
        bus.io_buffer_full = 1'b1;
        model_write(32'h2_0000, 1, 32'(v));
        req_data(1'b1, 2'd0, 32'h2_0000, 32'(v));
        observe(6);
        n_checks++;
        if (obs_cyc !== 1 || obs_wr[0] !== 1'b1) $display("FAIL io_nonio_write: got done cycle %0d wr0 %0b, want 1 and 1", obs_cyc, obs_wr[0]);
        else n_pass++;
        bus.io_buffer_full = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        bus.inst_read_flag = 1'b0;
        bus.inst_read_addr = 32'd0;
        bus.data_req       = 1'b0;
        bus.data_we        = 1'b0;
        bus.data_len       = 2'd0;
        bus.data_addr      = 32'd0;
        bus.data_wdata     = 32'd0;
`ifdef MEM_CTRL_IO_STALL_EN
        bus.io_buffer_full = 1'b0;
`endif
        rst = 1'b1;
        rdy = 1'b1;
        test_reset();
        test_fetch();
        test_store();
        test_priority();
        test_abort();
        test_freeze_reset();
        test_random();
`ifdef MEM_CTRL_IO_STALL_EN
        test_io_stall();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Memory controller between the instruction cache and the MEM stage on one side, and the single-port byte-wide RAM/IO bus on the other. It arbitrates instruction-fetch and data-access requests and serializes each into byte transactions, little-endian. It assembles read bytes into 32-bit words and returns a one-cycle completion pulse to the requester. The i_cache drives its instruction-side request and consumes its instruction-side response.

Parameters:
ADDR_W, 32, byte address width of all address ports and mem_a
DATA_W, 32, width of instruction and data words

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
rdy  input  1  global run enable; 0 freezes all state
inst_read_flag  input  1  instruction fetch request (level, held until inst_flag)
inst_read_addr  input  ADDR_W  fetch address
inst_flag  output  1  fetch complete, one-cycle pulse
inst  output  DATA_W  fetched instruction, valid while inst_flag=1
data_req  input  1  data access request (level, held until data_done)
data_we  input  1  1=write, 0=read
data_len  input  2  byte count minus 1: 0=1B, 1=2B, 3=4B (2 is illegal, treated as 4B)
data_addr  input  ADDR_W  data byte address
data_wdata  input  DATA_W  write data, byte 0 = bits [7:0]
data_done  output  1  data access complete, one-cycle pulse
data_rdata  output  DATA_W  read data, zero-extended, valid while data_done=1
mem_din  input  8  RAM read byte, 1-cycle latency after mem_a
mem_dout  output  8  RAM write byte
mem_a  output  ADDR_W  RAM byte address
mem_wr  output  1  RAM write strobe, 1=write
io_buffer_full  input  1  present only with MEM_CTRL_IO_STALL_EN

Behaviour:
- Reset (rst=1 at an edge): state IDLE; inst_flag=0, inst=0, data_done=0, data_rdata=0, mem_a=0, mem_dout=0, mem_wr=0, counters and holding registers 0. Reset mid-transaction aborts it with no completion pulse.
- rdy=0: no state, counter or output register changes; mem_wr forced 0 combinationally.
- States: IDLE, IREAD, DREAD, DWRITE, DONE.
- IDLE: if data_req=1, latch addr/we/len/wdata and go to DREAD or DWRITE. Otherwise, if inst_read_flag=1, latch inst_read_addr and go to IREAD. Data wins simultaneous requests. Request inputs are ignored outside IDLE.
- Cycle numbering: cycle 0 is the first cycle after the sampling edge. N = bytes (4 for IREAD).
- Reads: cycle k (0..N-1) drives mem_a=addr+k and mem_wr=0. The byte arriving in cycle k+1 is captured into word bits [8k+7:8k]. After the capture in cycle N, go to DONE. inst_flag or data_done is high in cycle N+1. Fetch latency: 5 cycles after sampling.
- Writes: cycle k (0..N-1) drives mem_wr=1, mem_a=addr+k, mem_dout=wdata[8k+7:8k]. DONE occurs in cycle N; data_done is high there, data_rdata=0.
- DONE: lasts exactly one cycle, asserts the matching completion output, then returns to IDLE. IDLE does not sample in the DONE cycle, so the requester has one cycle to drop or change its request.
- IREAD abort: if inst_read_flag=0 during IREAD (branch flush), go to IDLE at the next edge with no inst_flag. Bytes already read are discarded. Data transactions never abort except on reset.
- Address arithmetic is modulo 2^ADDR_W; addr=0xFFFFFFFF wraps to 0. Alignment is not checked.
- Outside an active transfer cycle: mem_wr=0, and mem_a holds its last value.

Optional Feature:
MEM_CTRL_IO_STALL_EN
- Defined: the io_buffer_full port exists. In DWRITE, when addr[17:16]=2'b11 (IO space) and io_buffer_full=1, the controller holds the current byte with mem_wr=0 and the counter unchanged. It resumes when io_buffer_full=0.
- Undefined: the port is absent and writes never stall.

Test Plan:
- Fetch from 0x100 with RAM bytes 13,05,00,00 at 0x100..0x103 -> mem_a 0x100..0x103 in cycles 0-3; inst_flag=1, inst=0x00000513 in cycle 5 only.
- SW data_addr=0x20, data_wdata=0xDEADBEEF, len=3 -> mem_wr=1 with bytes EF,BE,AD,DE at 0x20..0x23 in cycles 0-3; data_done in cycle 4.
- Simultaneous inst_read_flag (0x0) and 1-byte read (0x40, byte 0x80) -> data served first, data_rdata=0x00000080; fetch starts the cycle after DONE+IDLE.
- Fetch at 0x8, inst_read_flag dropped in cycle 2 -> no inst_flag; IDLE in cycle 3; new fetch at 0x40 returns the correct word.
- rdy=0 for 3 cycles mid-write, then rst=1 mid-read -> no progress and mem_wr=0 while frozen; after reset all outputs are 0 and state is IDLE.
- (MEM_CTRL_IO_STALL_EN) byte write to 0x30000 with io_buffer_full=1 for 4 cycles -> mem_wr=0 for 4 cycles, then a single write; data_done follows.
